// File: rtl/bus_interface_if.sv
// Request/response handshake and 16-bit external memory bus for bus_interface.
// slave = the bus interface block itself; master = control unit plus memory side.
interface bus_interface_if;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic          req_word;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_ale;
  logic [AW-1:0] mem_addr;
  logic          mem_bhe_n;
  logic          mem_rd_n;
  logic          mem_wr_n;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  req_valid, req_addr, req_we, req_word, req_wdata, mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_ale, mem_addr, mem_bhe_n, mem_rd_n, mem_wr_n, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_word, req_wdata, mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_ale, mem_addr, mem_bhe_n, mem_rd_n, mem_wr_n, mem_wdata
  );
endinterface

// File: rtl/bus_interface.sv
// 8086-style T1..T4 bus cycle engine with byte lanes, wait states and odd-word splitting.
// Optional BIU_TIMEOUT_EN: abort after TIMEOUT_CYCLES consecutive TW cycles with rsp_err.
module bus_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic            clk,
  input logic            rst_n,
  bus_interface_if.slave bus
);
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic          word_q, word_d;
  logic          half_q, half_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          mem_ale_q, mem_ale_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_bhe_n_q, mem_bhe_n_d;
  logic          mem_rd_n_q, mem_rd_n_d;
  logic          mem_wr_n_q, mem_wr_n_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [AW-1:0] cur_addr_c;
  logic          strobe_c;
  logic          abort_c;

`ifdef BIU_TIMEOUT_EN
  localparam int unsigned TW_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW_CNT_W-1:0] tw_cnt_q, tw_cnt_d;
  logic                err_q, err_d;
  assign abort_c = err_q;
`else
  assign abort_c = 1'b0;
`endif

  // Next state, request latching, read-lane capture; outputs derive from the next state
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    word_d      = word_q;
    half_d      = half_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
`ifdef BIU_TIMEOUT_EN
    tw_cnt_d    = tw_cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          word_d  = bus.req_word;
          wdata_d = bus.req_wdata;
          half_d  = 1'b0;
          rdata_d = '0;
`ifdef BIU_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3, S_TW: begin
        if (bus.mem_ready) begin
          if (word_q && !addr_q[0]) rdata_d = bus.mem_rdata;
          else if (half_q)          rdata_d[15:8] = bus.mem_rdata[7:0];
          else                      rdata_d[7:0] = addr_q[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
          state_d = S_T4;
        end else begin
`ifdef BIU_TIMEOUT_EN
          if (state_q == S_TW) tw_cnt_d = tw_cnt_q + TW_CNT_W'(1);
          if (state_q == S_TW && tw_cnt_q == TW_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = S_T4;
          end else begin
            state_d = S_TW;
          end
`else
          state_d = S_TW;
`endif
        end
      end
      S_T4: begin
        // Odd word: low byte came from the high lane, fetch the high byte at addr+1
        if (word_q && addr_q[0] && !half_q && !abort_c) begin
          half_d  = 1'b1;
          state_d = S_T1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (we_q || abort_c) ? '0 : rdata_q;
          rsp_err_d   = abort_c;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BIU_TIMEOUT_EN
    if (state_d == S_T1) tw_cnt_d = '0;
`endif

    cur_addr_c  = half_d ? AW'(addr_d + AW'(1)) : addr_d;
    strobe_c    = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);

    req_ready_d = (state_d == S_IDLE);
    mem_ale_d   = (state_d == S_T1);
    mem_rd_n_d  = !(strobe_c && !we_d);
    mem_wr_n_d  = !(strobe_c && we_d);
    mem_addr_d  = (state_d == S_T1) ? cur_addr_c : mem_addr_q;

    mem_bhe_n_d = mem_bhe_n_q;
    if (state_d == S_T1)        mem_bhe_n_d = half_d || !(addr_d[0] || word_d);
    else if (state_d == S_IDLE) mem_bhe_n_d = 1'b1;

    mem_wdata_d = mem_wdata_q;
    if (state_d == S_T2 && we_d) begin
      if (half_d)         mem_wdata_d = {8'h00, wdata_d[15:8]};
      else if (addr_d[0]) mem_wdata_d = {wdata_d[7:0], 8'h00};
      else if (word_d)    mem_wdata_d = wdata_d;
      else                mem_wdata_d = {8'h00, wdata_d[7:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      half_q      <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_ale_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_bhe_n_q <= 1'b1;
      mem_rd_n_q  <= 1'b1;
      mem_wr_n_q  <= 1'b1;
      mem_wdata_q <= '0;
`ifdef BIU_TIMEOUT_EN
      tw_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      word_q      <= word_d;
      half_q      <= half_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_ale_q   <= mem_ale_d;
      mem_addr_q  <= mem_addr_d;
      mem_bhe_n_q <= mem_bhe_n_d;
      mem_rd_n_q  <= mem_rd_n_d;
      mem_wr_n_q  <= mem_wr_n_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef BIU_TIMEOUT_EN
      tw_cnt_q    <= tw_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_ale   = mem_ale_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_bhe_n = mem_bhe_n_q;
  assign bus.mem_rd_n  = mem_rd_n_q;
  assign bus.mem_wr_n  = mem_wr_n_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_bus_interface.sv
// Bench for bus_interface: directed vector table, reset-abort sequence, random requests
// against a byte-addressed memory model; timeout scenario when BIU_TIMEOUT_EN is defined.
module tb_bus_interface;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_interface_if bi();

  bus_interface #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [7:0]  data;
  } lane_t;

  typedef struct {
    logic [19:0] addr;
    logic        we;
    logic        word;
    logic [15:0] wdata;
    int          w;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    wait_cfg = 0;
  int    cur_w = 0;
  int    tw_total = 0;
  int    k = 0;
  lane_t lane_obs[$];
  lane_t lane_exp[$];

  // Memory contents as a pure function of byte address
  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    if (a == 20'h12344) return 8'hEF;
    if (a == 20'h12345) return 8'hBE;
    if (a == 20'hFFFFF) return 8'h34;
    if (a == 20'h00000) return 8'h12;
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[3:0]} ^ 8'h5A;
  endfunction

  assign bi.mem_rdata = {mem_byte({bi.mem_addr[19:1], 1'b1}), mem_byte({bi.mem_addr[19:1], 1'b0})};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory side: wait states per bus cycle, and a log of enabled byte lanes at T2
  always @(negedge clk) begin
    lane_t l;
    if (!rst_n) begin
      k = 0;
      bi.mem_ready = 1'b0;
    end else begin
      if (bi.mem_ale) begin
        cur_w = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        tw_total += cur_w;
      end
      if (!bi.mem_rd_n || !bi.mem_wr_n) k++;
      else k = 0;
      if (k == 1) begin
        if (!bi.mem_addr[0]) begin
          l.we = !bi.mem_wr_n; l.addr = {bi.mem_addr[19:1], 1'b0};
          l.data = l.we ? bi.mem_wdata[7:0] : 8'h00;
          lane_obs.push_back(l);
        end
        if (!bi.mem_bhe_n) begin
          l.we = !bi.mem_wr_n; l.addr = {bi.mem_addr[19:1], 1'b1};
          l.data = l.we ? bi.mem_wdata[15:8] : 8'h00;
          lane_obs.push_back(l);
        end
      end
      bi.mem_ready = (k >= 2 + cur_w);
    end
  end

  // Called at a negedge with the block idle; returns at the negedge showing rsp_valid
  task automatic do_req(input logic [19:0] a, input logic we, input logic word, input logic [15:0] wd,
                        output logic [15:0] got_rdata, output int got_lat);
    logic [19:0] a1;
    logic [15:0] exp_rd;
    lane_t       l;
    int          n;
    int          exp_lat;
    a1 = 20'(a + 20'd1);
    check("req_ready_idle", 32'(bi.req_ready), 32'd1);
    lane_exp.delete(); lane_obs.delete(); tw_total = 0;
    l.we = we; l.addr = a; l.data = we ? wd[7:0] : 8'h00;
    lane_exp.push_back(l);
    if (word) begin
      l.addr = a1; l.data = we ? wd[15:8] : 8'h00;
      lane_exp.push_back(l);
    end
    exp_rd = word ? {mem_byte(a1), mem_byte(a)} : {8'h00, mem_byte(a)};
    bi.req_valid = 1'b1; bi.req_addr = a; bi.req_we = we; bi.req_word = word; bi.req_wdata = wd;
    @(negedge clk);
    bi.req_valid = 1'b0;
    check("ale_t1", 32'(bi.mem_ale), 32'd1);
    check("addr_t1", 32'(bi.mem_addr), 32'(a));
    check("ready_busy", 32'(bi.req_ready), 32'd0);
    n = 1;
    while (!bi.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    got_lat = n - 1;
    got_rdata = bi.rsp_rdata;
    exp_lat = ((word && a[0]) ? 8 : 4) + tw_total;
    check("rsp_seen", 32'(bi.rsp_valid), 32'd1);
    check("latency", 32'(got_lat), 32'(exp_lat));
    check("rsp_err", 32'(bi.rsp_err), 32'd0);
    check("ready_in_rsp", 32'(bi.req_ready), 32'd1);
    if (!we) check("rdata_model", 32'(got_rdata), 32'(exp_rd));
    check("lane_count", 32'(lane_obs.size()), 32'(lane_exp.size()));
    for (int i = 0; i < lane_exp.size() && i < lane_obs.size(); i++)
      check("lane", 32'(lane_obs[i]), 32'(lane_exp[i]));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tab[9];
    logic [15:0] rd;
    int          lat;
    int          n;
    logic        saw;
    logic [19:0] ra;

    tab[0] = '{20'h12344, 1'b0, 1'b1, 16'h0000, 0, 16'hBEEF, 4};
    tab[1] = '{20'h00101, 1'b1, 1'b0, 16'h00A5, 0, 16'h0000, 4};
    tab[2] = '{20'hFFFFF, 1'b0, 1'b1, 16'h0000, 0, 16'h1234, 8};
    tab[3] = '{20'h12344, 1'b0, 1'b1, 16'h0000, 3, 16'hBEEF, 7};
    tab[4] = '{20'h12345, 1'b0, 1'b0, 16'h0000, 1, 16'h00BE, 5};
    tab[5] = '{20'h12344, 1'b0, 1'b0, 16'h0000, 0, 16'h00EF, 4};
    tab[6] = '{20'hFFFFF, 1'b0, 1'b0, 16'h0000, 2, 16'h0034, 6};
    tab[7] = '{20'hFFFFF, 1'b1, 1'b1, 16'h5678, 1, 16'h0000, 10};
    tab[8] = '{20'hFFFFF, 1'b0, 1'b1, 16'h0000, 2, 16'h1234, 12};

    rst_n = 1'b0;
    bi.req_valid = 1'b0; bi.req_addr = '0; bi.req_we = 1'b0; bi.req_word = 1'b0; bi.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bi.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bi.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bi.rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(bi.rsp_rdata), 32'd0);
    check("rst_ale", 32'(bi.mem_ale), 32'd0);
    check("rst_rd_n", 32'(bi.mem_rd_n), 32'd1);
    check("rst_wr_n", 32'(bi.mem_wr_n), 32'd1);
    check("rst_bhe_n", 32'(bi.mem_bhe_n), 32'd1);
    check("rst_addr", 32'(bi.mem_addr), 32'd0);
    check("rst_wdata", 32'(bi.mem_wdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back-to-back
    for (int i = 0; i < 9; i++) begin
      wait_cfg = tab[i].w;
      do_req(tab[i].addr, tab[i].we, tab[i].word, tab[i].wdata, rd, lat);
      check("vec_latency", 32'(lat), 32'(tab[i].exp_lat));
      if (!tab[i].we) check("vec_rdata", 32'(rd), 32'(tab[i].exp_rdata));
    end

    // Reset during T2 of a write
    wait_cfg = 0;
    bi.req_valid = 1'b1; bi.req_addr = 20'h00300; bi.req_we = 1'b1; bi.req_word = 1'b1; bi.req_wdata = 16'hCAFE;
    @(negedge clk);
    bi.req_valid = 1'b0;
    @(negedge clk);
    check("t2_wr_n_low", 32'(bi.mem_wr_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_wr_n", 32'(bi.mem_wr_n), 32'd1);
    check("rst_async_ready", 32'(bi.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bi.rsp_valid) saw = 1'b1;
    end
    check("no_rsp_after_reset", 32'(saw), 32'd0);
    do_req(20'h12344, 1'b0, 1'b1, 16'h0000, rd, lat);
    check("post_reset_rdata", 32'(rd), 32'h0000BEEF);

`ifdef BIU_TIMEOUT_EN
    wait_cfg = 1000;
    bi.req_valid = 1'b1; bi.req_addr = 20'h00200; bi.req_we = 1'b0; bi.req_word = 1'b1;
    @(negedge clk);
    bi.req_valid = 1'b0;
    n = 1;
    while (!bi.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", 32'(n - 1), 32'd8);
    check("to_rsp_err", 32'(bi.rsp_err), 32'd1);
    check("to_rdata", 32'(bi.rsp_rdata), 32'd0);
    @(negedge clk);
    check("to_idle_ready", 32'(bi.req_ready), 32'd1);
    check("to_single_pulse", 32'(bi.rsp_valid), 32'd0);
`else
    n = 0;
`endif

    // Random requests against the memory model
    wait_cfg = -1;
    for (int i = 0; i < 60; i++) begin
      ra = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {16'hFFFF, ra[3:0]};
      do_req(ra, 1'($urandom), 1'($urandom), 16'($urandom), rd, lat);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
